// File: rtl/multicore_dispatcher.sv
// multicore_dispatcher: program sequencer for the core array.
// Fetches from a fixed-latency program BRAM, resolves NOP/END/LOOP/SYNC
// locally and broadcasts every other instruction to the cores with a
// per-core valid/ready handshake.
module multicore_dispatcher #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int INSTRUCTION_COUNT = 8,
    parameter int CORE_COUNT        = 4,
    parameter int LOOP_DEPTH        = 4,
    parameter int BRAM_LATENCY      = 2,
    localparam int PCW = (INSTRUCTION_COUNT > 1) ? $clog2(INSTRUCTION_COUNT) : 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    output logic [PCW-1:0]               instr_addr_out,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] issue_instr_out,
    output logic [CORE_COUNT-1:0]        issue_valid_out,
    input  logic [CORE_COUNT-1:0]        core_ready_in,
    input  logic [CORE_COUNT-1:0]        core_idle_in,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         error_out,
    output logic [PCW-1:0]               pc_out,
    output logic [2:0]                   state_out
);
    localparam int PCW1 = PCW + 1;
    localparam int SPW  = $clog2(LOOP_DEPTH + 1);
    localparam int LIW  = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam int CW   = $clog2(BRAM_LATENCY + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_DISPATCH = 3'd3;
    localparam logic [2:0] S_SYNC     = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    localparam logic [3:0] OP_NOP      = 4'b0000;
    localparam logic [3:0] OP_LOOP_SET = 4'b0001;
    localparam logic [3:0] OP_LOOP_END = 4'b0010;
    localparam logic [3:0] OP_SYNC     = 4'b0011;
    localparam logic [3:0] OP_END      = 4'b1111;

    logic [2:0]                   state, state_d;
    logic [PCW-1:0]               pc, pc_d;
    logic [CW-1:0]                fetch_cnt;
    logic [SPW-1:0]               sp;
    logic                         error;
    logic [INSTRUCTION_WIDTH-1:0] issue_instr;
    logic [CORE_COUNT-1:0]        pending;

    logic [PCW-1:0]               loop_addr [LOOP_DEPTH];
    logic [15:0]                  loop_cnt  [LOOP_DEPTH];

    logic                         restart, push, pop, dec, err_set, done_evt, latch, adv;

    // Decode helpers; the PC increment is one bit wider so overrun is visible
    logic [3:0]            opcode;
    logic [15:0]           imm;
    logic [CORE_COUNT-1:0] raw_mask, dispatch_mask;
    logic [PCW:0]          pc_inc;
    logic                  overrun;
    logic [LIW-1:0]        push_idx, top_idx;
    logic [15:0]           top_cnt;

    assign opcode        = instr_data_in[INSTRUCTION_WIDTH-1 -: 4];
    assign imm           = instr_data_in[15:0];
    assign raw_mask      = instr_data_in[INSTRUCTION_WIDTH-5 -: CORE_COUNT];
    assign dispatch_mask = (raw_mask == '0) ? '1 : raw_mask;
    assign pc_inc        = {1'b0, pc} + 1'b1;
    assign overrun       = (pc_inc >= PCW1'(INSTRUCTION_COUNT));
    assign push_idx      = LIW'(sp);
    assign top_idx       = LIW'(sp - 1'b1);
    assign top_cnt       = loop_cnt[top_idx];

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state and control events
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        restart  = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        dec      = 1'b0;
        err_set  = 1'b0;
        done_evt = 1'b0;
        latch    = 1'b0;
        adv      = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start_in) begin
                    restart = 1'b1;
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                if (fetch_cnt == CW'(BRAM_LATENCY - 1)) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP: adv = 1'b1;
                    OP_END: begin
                        done_evt = 1'b1;
                        state_d  = S_HALT;
                    end
                    OP_LOOP_SET: begin
                        if (sp == SPW'(LOOP_DEPTH)) begin
                            err_set = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            push = 1'b1;
                            adv  = 1'b1;
                        end
                    end
                    OP_LOOP_END: begin
                        if (sp == '0) begin
                            err_set = 1'b1;
                            state_d = S_HALT;
                        end else if (top_cnt > 16'd1) begin
                            dec     = 1'b1;
                            pc_d    = loop_addr[top_idx];
                            state_d = S_FETCH;
                        end else begin
                            pop = 1'b1;
                            adv = 1'b1;
                        end
                    end
                    OP_SYNC: state_d = S_SYNC;
                    default: begin
                        latch   = 1'b1;
                        state_d = S_DISPATCH;
                    end
                endcase
            end
            // Leave once no pending core remains unaccepted after this cycle
            S_DISPATCH: if ((pending & ~core_ready_in) == '0) adv = 1'b1;
            S_SYNC:     if (&core_idle_in) adv = 1'b1;
            default:    state_d = S_IDLE;
        endcase
        // Sequential advance; running off the end of the program is a clean END
        if (adv) begin
            if (overrun) begin
                done_evt = 1'b1;
                state_d  = S_HALT;
            end else begin
                pc_d    = pc_inc[PCW-1:0];
                state_d = S_FETCH;
            end
        end
    end

    // Outputs: valids come only from registered pending bits, never from ready
    always_comb begin
        busy_out        = (state != S_IDLE) && (state != S_HALT);
        done_out        = done_evt;
        issue_valid_out = (state == S_DISPATCH) ? pending : '0;
    end

    assign instr_addr_out  = pc;
    assign pc_out          = pc;
    assign state_out       = state;
    assign error_out       = error;
    assign issue_instr_out = issue_instr;

    // Datapath: PC, fetch latency counter, stack pointer, error, issue latch
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc          <= '0;
            fetch_cnt   <= '0;
            sp          <= '0;
            error       <= 1'b0;
            issue_instr <= '0;
            pending     <= '0;
        end else begin
            pc        <= pc_d;
            fetch_cnt <= (state == S_FETCH) ? fetch_cnt + 1'b1 : '0;
            if (restart) begin
                error <= 1'b0;
                sp    <= '0;
            end else begin
                if (err_set) error <= 1'b1;
                if (push)     sp <= sp + 1'b1;
                else if (pop) sp <= sp - 1'b1;
            end
            if (latch) begin
                issue_instr <= instr_data_in;
                pending     <= dispatch_mask;
            end else if (state == S_DISPATCH) begin
                pending <= pending & ~core_ready_in;
            end
        end
    end

    // Loop stack storage; emptiness is tracked by sp alone
    always_ff @(posedge clk_in) begin
        if (push) begin
            loop_addr[push_idx] <= pc_inc[PCW-1:0];
            loop_cnt[push_idx]  <= (imm == 16'd0) ? 16'd1 : imm;
        end else if (dec) begin
            loop_cnt[top_idx] <= top_cnt - 16'd1;
        end
    end
endmodule

// File: tb/tb_multicore_dispatcher.sv
// Directed bench for multicore_dispatcher with a 2-cycle BRAM model.
module tb_multicore_dispatcher;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  instr_addr;
    logic [31:0] rdata, d1;
    logic [31:0] issue_instr;
    logic [3:0]  valid, ready, idle;
    logic        busy, done, error;
    logic [2:0]  pc, state;

    logic [31:0] prog [8];
    int          n_asserts = 0;
    int          n_fail    = 0;
    int          done_cnt  = 0;

    multicore_dispatcher #(
        .INSTRUCTION_WIDTH(32), .INSTRUCTION_COUNT(8), .CORE_COUNT(4),
        .LOOP_DEPTH(4), .BRAM_LATENCY(2)
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .instr_addr_out(instr_addr), .instr_data_in(rdata),
        .issue_instr_out(issue_instr), .issue_valid_out(valid),
        .core_ready_in(ready), .core_idle_in(idle),
        .busy_out(busy), .done_out(done), .error_out(error),
        .pc_out(pc), .state_out(state)
    );

    always #5 clk = ~clk;

    // Program BRAM, two-cycle read latency
    always @(posedge clk) begin
        d1    <= prog[instr_addr];
        rdata <= d1;
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (state == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        bit ok;
        int done_at, ndisp, nbad, d0;
        rst = 1'b1; start = 1'b0; ready = 4'h0; idle = 4'hF;
        for (int i = 0; i < 8; i++) prog[i] = 32'h0;
        d1 = 32'h0; rdata = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", instr_addr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", issue_instr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", state, 0);

        // All-NOP program: done 24 cycles after the start cycle, via PC overrun
        done_at = 0;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                chk("nop_busy", busy, 1);
            end
            if (done && done_at == 0) done_at = c;
        end
        chk("nop_done_cycle", done_at, 24);
        chk("nop_halt", state, 5);
        chk("nop_error", error, 0);
        chk("nop_not_busy", busy, 0);

        // LOOP_SET 3 / dispatch / LOOP_END / END
        prog[0] = 32'h1000_0003;
        prog[1] = 32'h4000_0000;
        prog[2] = 32'h2000_0000;
        prog[3] = 32'hF000_0000;
        ready = 4'hF;
        ndisp = 0; nbad = 0; d0 = done_cnt;
        start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (valid != 4'h0) begin
                ndisp++;
                if (valid !== 4'hF || issue_instr !== 32'h4000_0000) nbad++;
            end
        end
        chk("loop_dispatches", ndisp, 3);
        chk("loop_dispatch_bits", nbad, 0);
        chk("loop_done_pulses", done_cnt - d0, 1);
        chk("loop_halt", state, 5);
        chk("loop_error", error, 0);

        // Masked dispatch 0101, core0 ready at once, core2 five cycles later
        prog[0] = 32'h45AB_CDE5;
        prog[1] = 32'hF000_0000;
        ready = 4'h0;
        pulse_start();
        wait_state(3'd3, 20, ok);
        chk("mask_reach_dispatch", ok, 1);
        chk("mask_valid_first", valid, 4'b0101);
        chk("mask_instr_first", issue_instr, 32'h45AB_CDE5);
        ready = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("mask_valid_held", valid, 4'b0100);
            chk("mask_instr_held", issue_instr, 32'h45AB_CDE5);
            ready = (i == 5) ? 4'b0100 : 4'b0000;
        end
        @(negedge clk);
        ready = 4'h0;
        chk("mask_back_to_fetch", state, 1);
        chk("mask_valid_dropped", valid, 0);
        chk("mask_pc", pc, 1);
        wait_state(3'd5, 20, ok);
        chk("mask_halt", ok, 1);

        // SYNC waits on core_idle_in
        prog[0] = 32'h3000_0000;
        prog[1] = 32'hF000_0000;
        idle = 4'b1011;
        pulse_start();
        wait_state(3'd4, 20, ok);
        chk("sync_reach", ok, 1);
        for (int i = 2; i <= 7; i++) begin
            @(negedge clk);
            chk("sync_hold", state, 4);
        end
        @(negedge clk);
        chk("sync_exit_cycle", state, 4);
        idle = 4'hF;
        @(negedge clk);
        chk("sync_exit_fetch", state, 1);
        chk("sync_pc", pc, 1);
        wait_state(3'd5, 20, ok);
        chk("sync_halt", ok, 1);

        // Five nested LOOP_SET overflow a four-deep stack
        for (int i = 0; i < 5; i++) prog[i] = 32'h1000_0002;
        prog[5] = 32'hF000_0000;
        d0 = done_cnt;
        pulse_start();
        wait_state(3'd5, 60, ok);
        chk("ovf_halt", ok, 1);
        chk("ovf_error", error, 1);
        chk("ovf_no_done", done_cnt - d0, 0);
        chk("ovf_pc", pc, 4);
        pulse_start();
        chk("restart_clears_error", error, 0);
        chk("restart_fetch", state, 1);
        chk("restart_pc", pc, 0);
        wait_state(3'd5, 60, ok);
        chk("ovf2_halt", ok, 1);

        // LOOP_END on an empty stack
        prog[0] = 32'h2000_0000;
        d0 = done_cnt;
        pulse_start();
        wait_state(3'd5, 20, ok);
        chk("empty_halt", ok, 1);
        chk("empty_error", error, 1);
        chk("empty_no_done", done_cnt - d0, 0);

        // Reset in the middle of a broadcast
        prog[0] = 32'h4000_0000;
        ready = 4'h0;
        pulse_start();
        wait_state(3'd3, 20, ok);
        chk("rstd_reach", ok, 1);
        chk("rstd_valid", valid, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        chk("rstd_valid_drop", valid, 0);
        chk("rstd_state", state, 0);
        chk("rstd_pc", pc, 0);
        chk("rstd_busy", busy, 0);
        chk("rstd_error", error, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
